machine_line_decoder: RTL and testbench
=======================================

// Module: machine_line_decoder
// PURPOSE
//  Upstream stage of the machine compute units: parses the ASCII puzzle input one byte at a time.
//  Emits one wiring word for the indicator-light diagram [..##.], then one per button group (a,b,..).
//  Emits an end_of_line pulse per machine and an end_of_file level at end of input.
//  Skips joltage groups {..}. Sits between the byte-stream receiver and machine_compute_units.
// PARAMETERS
//  MAX_WIRING_WIDTH   16  wiring word width; max light count / button index+1
//  INDEX_WIDTH         8  decimal button-index accumulator width; must satisfy 2**INDEX_WIDTH > 10*MAX_WIRING_WIDTH
// PORTS
//  clk             in   1                 single clock, all logic rising edge
//  rst_n           in   1                 asynchronous assert, active-low reset
//  inbound_valid   in   1                 byte strobe; no backpressure, one byte per cycle max
//  inbound_data    in   8                 ASCII byte
//  end_of_file     out  1                 level; high from EOT until reset
//  end_of_line     out  1                 one-cycle pulse per completed machine line
//  wiring_valid    out  1                 one-cycle pulse, wiring_data qualified
//  wiring_data     out  MAX_WIRING_WIDTH  light pattern or button wiring, bit k = position/index k
//  decode_error    out  1                 sticky; malformed input seen
// BEHAVIOUR
//  Reset: all outputs 0, state LINE_START, accumulators cleared. Outputs registered: 1-cycle latency after closing byte.
//  Reset mid-line discards the partial line; no pulses are produced for it.
//  FSM (transitions only on inbound_valid; no transition when inbound_valid=0):
//   LINE_START: '[' -> LIGHTS (pattern=0, pos=0); '\n' -> stay, no pulse (empty line);
//               0x04 EOT -> DONE; space/'\r' ignored.
//   LIGHTS: '#' sets bit pos, pos++; '.' pos++; ']' -> BETWEEN, wiring_valid with pattern.
//   BETWEEN: '(' -> BUTTON (word=0, idx=0); '{' -> JOLTAGE; '\n' -> LINE_START, end_of_line pulse;
//            EOT -> DONE; space/'\r' ignored.
//   BUTTON: digit -> idx = idx*10 + digit; ',' sets bit idx, idx=0;
//           ')' sets bit idx, wiring_valid with word, -> BETWEEN.
//   JOLTAGE: all bytes ignored until '}' -> BETWEEN.
//   DONE: end_of_file=1; all further bytes ignored; outputs otherwise idle.
//  EOT received in BETWEEN: end_of_line pulse and end_of_file rise in the same cycle.
//  EOT received in LINE_START: end_of_file only, no end_of_line.
//  Light diagram bit order: leftmost character = bit 0.
//  Wiring words are emitted in input order. end_of_line always follows the last wiring of its line,
//   never in the same cycle.
//  Error cases (set decode_error, keep parsing):
//   - pos >= MAX_WIRING_WIDTH: character dropped.
//   - idx >= MAX_WIRING_WIDTH at ',' or ')': bit not set.
//   - idx saturates at all-ones rather than wrapping.
//   - unexpected byte in any state: byte ignored, state unchanged.
//   - EOT inside LIGHTS/BUTTON/JOLTAGE: -> DONE, partial word and end_of_line suppressed.
//  Duplicate index in a group: bit set once (idempotent OR).
// STRUCTURE
//  Shared package aoc_25_10_pkg holds:
//   - wiring_t typedef (shared with machine_compute_units)
//   - ASCII constants: CHAR_LBRACK, CHAR_RBRACK, CHAR_LPAREN, CHAR_RPAREN, CHAR_LBRACE, CHAR_RBRACE,
//     CHAR_HASH, CHAR_DOT, CHAR_COMMA, CHAR_LF, CHAR_CR, CHAR_EOT
//   - parser state enum.
//  One sub-module: decimal_index_accumulator (clear/digit/saturate, INDEX_WIDTH out).
//  FSM, pattern/word registers and output registers live in this module.
// TESTING
//  1. "[.##.] (3) (1,3) (2) (2,3) (0,2) (0,1) {3,5,4,7}\n", width 16
//     -> wiring 0x0006,0x0008,0x000A,0x0004,0x000C,0x0005,0x0003 in order, then one end_of_line pulse.
//  2. "[#] (10,12) (15)\n" -> 0x0001, 0x1400, 0x8000, end_of_line; decode_error stays 0.
//  3. Same as 1 with random inbound_valid gaps (0-5 idle cycles) -> identical output sequence, one pulse per event.
//  4. "[#.] (1)" then EOT, no trailing LF -> 0x0001, 0x0002, then end_of_line and end_of_file rise same cycle;
//     further bytes produce nothing.
//  5. "(16)" and "(300)" with width 16 -> decode_error=1 after each; emitted word 0x0000; next valid line decodes correctly.
//  6. rst_n low after "[.#" mid-line then release, send line 1
//     -> all outputs 0 during reset; output exactly matches scenario 1, no stale bits.

Source files
------------

// File: rtl/aoc_25_10_pkg.sv
// aoc_25_10_pkg: shared wiring type, ASCII constants and parser states for the machine pipeline
package aoc_25_10_pkg;
    localparam int MAX_WIRING_WIDTH = 16;
    localparam int INDEX_WIDTH = 8;
    typedef logic [MAX_WIRING_WIDTH-1:0] wiring_t;
    localparam logic [7:0] CHAR_LBRACK = 8'h5B;
    localparam logic [7:0] CHAR_RBRACK = 8'h5D;
    localparam logic [7:0] CHAR_LPAREN = 8'h28;
    localparam logic [7:0] CHAR_RPAREN = 8'h29;
    localparam logic [7:0] CHAR_LBRACE = 8'h7B;
    localparam logic [7:0] CHAR_RBRACE = 8'h7D;
    localparam logic [7:0] CHAR_HASH = 8'h23;
    localparam logic [7:0] CHAR_DOT = 8'h2E;
    localparam logic [7:0] CHAR_COMMA = 8'h2C;
    localparam logic [7:0] CHAR_LF = 8'h0A;
    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_EOT = 8'h04;
    localparam logic [7:0] CHAR_SPACE = 8'h20;
    typedef enum logic [2:0] {LINE_START, LIGHTS, BETWEEN, BUTTON, JOLTAGE, DONE} state_t;
    function automatic logic is_digit(input logic [7:0] c);
        return c >= 8'h30 && c <= 8'h39;
    endfunction
    function automatic logic is_blank(input logic [7:0] c);
        return c == CHAR_SPACE || c == CHAR_CR;
    endfunction
endpackage

// File: rtl/machine_line_decoder_if.sv
// machine_line_decoder_if: byte-stream input and decoded wiring/status outputs
interface machine_line_decoder_if #(parameter int W = 16);
    logic inbound_valid;
    logic [7:0] inbound_data;
    logic end_of_file;
    logic end_of_line;
    logic wiring_valid;
    logic [W-1:0] wiring_data;
    logic decode_error;
    modport master (
        output inbound_valid, inbound_data,
        input end_of_file, end_of_line, wiring_valid, wiring_data, decode_error
    );
    modport slave (
        input inbound_valid, inbound_data,
        output end_of_file, end_of_line, wiring_valid, wiring_data, decode_error
    );
endinterface

// File: rtl/decimal_index_accumulator.sv
// decimal_index_accumulator: builds a decimal button index digit by digit, saturating at all-ones
module decimal_index_accumulator #(parameter int INDEX_WIDTH = 8) (
    input logic clk,
    input logic rst_n,
    input logic clear,
    input logic digit_valid,
    input logic [3:0] digit,
    output logic [INDEX_WIDTH-1:0] idx
);
    logic [INDEX_WIDTH+3:0] next_idx;
    logic [INDEX_WIDTH-1:0] sat_idx;
    // widened multiply-add so an overflow is visible before it is clamped
    always_comb begin
        next_idx = {4'b0, idx} * (INDEX_WIDTH+4)'(10) + {{INDEX_WIDTH{1'b0}}, digit};
        sat_idx = |next_idx[INDEX_WIDTH+3:INDEX_WIDTH] ? '1 : next_idx[INDEX_WIDTH-1:0];
    end
    // clear wins over a digit so a new group always starts from zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) idx <= '0;
        else if (clear) idx <= '0;
        else if (digit_valid) idx <= sat_idx;
    end
endmodule

// File: rtl/machine_line_decoder.sv
// machine_line_decoder: parses ASCII machine lines into light-pattern and button wiring words
module machine_line_decoder
    import aoc_25_10_pkg::*;
#(
    parameter int MAX_WIRING_WIDTH = 16,
    parameter int INDEX_WIDTH = 8
) (
    input logic clk,
    input logic rst_n,
    machine_line_decoder_if.slave bus
);
    localparam int PW = $clog2(MAX_WIRING_WIDTH) + 1;
    state_t state;
    logic [MAX_WIRING_WIDTH-1:0] word;
    logic [PW-1:0] pos;
    logic [INDEX_WIDTH-1:0] idx;
    logic [7:0] c;
    logic v, idx_ok, pos_ok, acc_clear, acc_digit;
    logic [MAX_WIRING_WIDTH-1:0] idx_bit, pos_bit;
    // decode helpers: in-range checks and the one-hot bit each position/index would set
    always_comb begin
        c = bus.inbound_data;
        v = bus.inbound_valid;
        idx_ok = idx < INDEX_WIDTH'(MAX_WIRING_WIDTH);
        pos_ok = pos < PW'(MAX_WIRING_WIDTH);
        idx_bit = idx_ok ? MAX_WIRING_WIDTH'(1) << idx : '0;
        pos_bit = MAX_WIRING_WIDTH'(1) << pos;
        acc_clear = v && ((state == BETWEEN && c == CHAR_LPAREN) || (state == BUTTON && c == CHAR_COMMA));
        acc_digit = v && state == BUTTON && is_digit(c);
    end
    decimal_index_accumulator #(.INDEX_WIDTH(INDEX_WIDTH)) u_acc (
        .clk(clk),
        .rst_n(rst_n),
        .clear(acc_clear),
        .digit_valid(acc_digit),
        .digit(c[3:0]),
        .idx(idx)
    );
    // parser FSM with registered outputs; malformed bytes flag an error but never stall parsing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LINE_START;
            word <= '0;
            pos <= '0;
            bus.wiring_valid <= 1'b0;
            bus.wiring_data <= '0;
            bus.end_of_line <= 1'b0;
            bus.end_of_file <= 1'b0;
            bus.decode_error <= 1'b0;
        end else begin
            bus.wiring_valid <= 1'b0;
            bus.end_of_line <= 1'b0;
            if (v) begin
                case (state)
                    LINE_START:
                        if (c == CHAR_LBRACK) begin
                            state <= LIGHTS;
                            word <= '0;
                            pos <= '0;
                        end else if (c == CHAR_EOT) begin
                            state <= DONE;
                            bus.end_of_file <= 1'b1;
                        end else if (c != CHAR_LF && !is_blank(c)) bus.decode_error <= 1'b1;
                    LIGHTS:
                        if (c == CHAR_HASH || c == CHAR_DOT) begin
                            if (pos_ok) begin
                                word <= c == CHAR_HASH ? word | pos_bit : word;
                                pos <= pos + PW'(1);
                            end else bus.decode_error <= 1'b1;
                        end else if (c == CHAR_RBRACK) begin
                            state <= BETWEEN;
                            bus.wiring_valid <= 1'b1;
                            bus.wiring_data <= word;
                        end else if (c == CHAR_EOT) begin
                            state <= DONE;
                            bus.end_of_file <= 1'b1;
                            bus.decode_error <= 1'b1;
                        end else bus.decode_error <= 1'b1;
                    BETWEEN:
                        if (c == CHAR_LPAREN) begin
                            state <= BUTTON;
                            word <= '0;
                        end else if (c == CHAR_LBRACE) state <= JOLTAGE;
                        else if (c == CHAR_LF) begin
                            state <= LINE_START;
                            bus.end_of_line <= 1'b1;
                        end else if (c == CHAR_EOT) begin
                            state <= DONE;
                            bus.end_of_line <= 1'b1;
                            bus.end_of_file <= 1'b1;
                        end else if (!is_blank(c)) bus.decode_error <= 1'b1;
                    BUTTON:
                        if (c == CHAR_COMMA) begin
                            word <= word | idx_bit;
                            bus.decode_error <= bus.decode_error | !idx_ok;
                        end else if (c == CHAR_RPAREN) begin
                            state <= BETWEEN;
                            bus.wiring_valid <= 1'b1;
                            bus.wiring_data <= word | idx_bit;
                            bus.decode_error <= bus.decode_error | !idx_ok;
                        end else if (c == CHAR_EOT) begin
                            state <= DONE;
                            bus.end_of_file <= 1'b1;
                            bus.decode_error <= 1'b1;
                        end else if (!is_digit(c)) bus.decode_error <= 1'b1;
                    JOLTAGE:
                        if (c == CHAR_RBRACE) state <= BETWEEN;
                        else if (c == CHAR_EOT) begin
                            state <= DONE;
                            bus.end_of_file <= 1'b1;
                            bus.decode_error <= 1'b1;
                        end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_machine_line_decoder.sv
// tb_machine_line_decoder: directed and randomized line streams checked against an event model
module tb_machine_line_decoder;
    import aoc_25_10_pkg::*;
    typedef struct {
        int kind;
        wiring_t data;
        logic eof;
    } ev_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    machine_line_decoder_if bus();
    machine_line_decoder dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    ev_t got[$];
    ev_t exp[$];
    byte q[$];
    int checks = 0;
    int errors = 0;
    int overlap = 0;
    // record every output event; wiring and end_of_line must never coincide
    always @(negedge clk) if (rst_n) begin
        if (bus.wiring_valid) got.push_back('{0, bus.wiring_data, bus.end_of_file});
        if (bus.end_of_line) got.push_back('{1, '0, bus.end_of_file});
        if (bus.wiring_valid && bus.end_of_line) overlap++;
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
        end
    endtask
    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    endtask
    task automatic send(input int maxgap);
        while (q.size() > 0) begin
            bus.inbound_data = q.pop_front();
            bus.inbound_valid = 1'b1;
            @(posedge clk);
            #1;
            bus.inbound_valid = 1'b0;
            repeat ($urandom_range(maxgap, 0)) begin
                @(posedge clk);
                #1;
            end
        end
    endtask
    task automatic wiring(input wiring_t w);
        exp.push_back('{0, w, 1'b0});
    endtask
    task automatic eol(input logic eof);
        exp.push_back('{1, '0, eof});
    endtask
    task automatic check_events(input string tag);
        repeat (4) @(posedge clk);
        #1;
        chk({tag, "_count"}, got.size(), exp.size());
        for (int i = 0; i < got.size() && i < exp.size(); i++) begin
            chk($sformatf("%s_kind%0d", tag, i), got[i].kind, exp[i].kind);
            chk($sformatf("%s_data%0d", tag, i), 32'(got[i].data), 32'(exp[i].data));
            chk($sformatf("%s_eof%0d", tag, i), 32'(got[i].eof), 32'(exp[i].eof));
        end
        got.delete();
        exp.delete();
    endtask
    task automatic do_reset();
        rst_n = 1'b0;
        bus.inbound_valid = 1'b0;
        bus.inbound_data = '0;
        #1;
        chk("rst_wiring_valid", 32'(bus.wiring_valid), 0);
        chk("rst_wiring_data", 32'(bus.wiring_data), 0);
        chk("rst_end_of_line", 32'(bus.end_of_line), 0);
        chk("rst_end_of_file", 32'(bus.end_of_file), 0);
        chk("rst_decode_error", 32'(bus.decode_error), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        got.delete();
        exp.delete();
        @(posedge clk);
        #1;
    endtask
    task automatic line1();
        push_str("[.##.] (3) (1,3) (2) (2,3) (0,2) (0,1) {3,5,4,7}\n");
        wiring(16'h0006);
        wiring(16'h0008);
        wiring(16'h000A);
        wiring(16'h0004);
        wiring(16'h000C);
        wiring(16'h0005);
        wiring(16'h0003);
        eol(1'b0);
    endtask
    task automatic random_line();
        int n = $urandom_range(16, 1);
        int nb = $urandom_range(5, 1);
        wiring_t pat = '0;
        if ($urandom_range(3, 0) == 0) push_str("\n");
        push_str("[");
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(1, 0) == 1) begin
                pat = pat + (wiring_t'(1) << i);
                q.push_back(CHAR_HASH);
            end else q.push_back(CHAR_DOT);
        end
        push_str("]");
        wiring(pat);
        for (int b = 0; b < nb; b++) begin
            int ni = $urandom_range(4, 1);
            wiring_t w = '0;
            push_str(" (");
            for (int j = 0; j < ni; j++) begin
                int k = $urandom_range(15, 0);
                w = w | (wiring_t'(1) << k);
                push_str($sformatf("%0d", k));
                if (j < ni - 1) push_str(",");
            end
            push_str(")");
            wiring(w);
            if ($urandom_range(2, 0) == 0) push_str($sformatf(" {%0d,%0d}", $urandom_range(300, 0), $urandom_range(300, 0)));
        end
        if ($urandom_range(1, 0) == 1) push_str("\r");
        push_str("\n");
        eol(1'b0);
    endtask
    initial begin
        do_reset();
        line1();
        send(0);
        check_events("s1");
        push_str("[#] (10,12) (15)\n");
        wiring(16'h0001);
        wiring(16'h1400);
        wiring(16'h8000);
        eol(1'b0);
        send(0);
        check_events("s2");
        chk("s2_error", 32'(bus.decode_error), 0);
        line1();
        send(5);
        check_events("s3");
        repeat (20) begin
            random_line();
            send(3);
            check_events("rand");
        end
        chk("rand_error", 32'(bus.decode_error), 0);
        q.push_back(CHAR_EOT);
        send(0);
        check_events("eot_line_start");
        chk("eot_line_start_eof", 32'(bus.end_of_file), 1);
        do_reset();
        push_str("[#] (16)\n");
        wiring(16'h0001);
        wiring(16'h0000);
        eol(1'b0);
        send(0);
        check_events("s5a");
        chk("s5a_error", 32'(bus.decode_error), 1);
        do_reset();
        push_str("[#] (300)\n");
        wiring(16'h0001);
        wiring(16'h0000);
        eol(1'b0);
        send(0);
        check_events("s5b");
        chk("s5b_error", 32'(bus.decode_error), 1);
        line1();
        send(0);
        check_events("s5c");
        do_reset();
        push_str("[.#");
        send(0);
        do_reset();
        line1();
        send(0);
        check_events("s6");
        chk("s6_error", 32'(bus.decode_error), 0);
        do_reset();
        push_str("[#.] (1)");
        q.push_back(CHAR_EOT);
        wiring(16'h0001);
        wiring(16'h0002);
        eol(1'b1);
        send(0);
        check_events("s4");
        line1();
        exp.delete();
        send(1);
        check_events("s4_after");
        chk("s4_eof_held", 32'(bus.end_of_file), 1);
        chk("overlap", overlap, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
